// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares a single-port 128x8 RAM between a CPU port and a DMA/debug port
module ram_port_arbiter #(
  parameter bit          CPU_PRIO = 1'b0,
  parameter int unsigned LOCK_MAX = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       req0_i,
  input  logic       req1_i,
  input  logic       we0_i,
  input  logic       we1_i,
  input  logic [6:0] addr0_i,
  input  logic [6:0] addr1_i,
  input  logic [7:0] wdata0_i,
  input  logic [7:0] wdata1_i,
  input  logic       lock0_i,
  input  logic       lock1_i,
  output logic       gnt0_o,
  output logic       gnt1_o,
  output logic       ack0_o,
  output logic       ack1_o,
  output logic [7:0] rdata0_o,
  output logic [7:0] rdata1_o,
  output logic       lock_err_o,
  output logic [6:0] ram_addr_o,
  output logic [7:0] ram_data_o,
  output logic       ram_en_o,
  input  logic [7:0] ram_q_i
);
  typedef enum logic [1:0] {IDLE, ACCESS, HOLD} state_e;
  state_e     state_q;
  logic       owner_q, last_q, gnt0_q, gnt1_q, lock_err_q;
  logic [3:0] lock_cnt_q, lock_cnt_d;
  logic [7:0] rdata0_q, rdata1_q;
  logic       o_req, o_we, o_lock, in_acc, winner;
  logic [6:0] o_addr;
  logic [7:0] o_wdata;
  // Owner field select, arbitration and RAM/ack decode; everything keys off state so reset clears it at once
  always_comb begin
    o_req      = owner_q ? req1_i : req0_i;
    o_we       = owner_q ? we1_i : we0_i;
    o_lock     = owner_q ? lock1_i : lock0_i;
    o_addr     = owner_q ? addr1_i : addr0_i;
    o_wdata    = owner_q ? wdata1_i : wdata0_i;
    in_acc     = state_q == ACCESS;
    winner     = (req0_i & req1_i) ? (CPU_PRIO ? 1'b0 : ~last_q) : req1_i;
    lock_cnt_d = &lock_cnt_q ? lock_cnt_q : lock_cnt_q + 4'd1;
    ram_addr_o = in_acc ? o_addr : 7'd0;
    ram_data_o = in_acc ? o_wdata : 8'd0;
    ram_en_o   = in_acc & o_req & o_we;
    ack0_o     = in_acc & ~owner_q & req0_i;
    ack1_o     = in_acc & owner_q & req1_i;
  end
  // Arbitration FSM: IDLE picks a winner, ACCESS performs one transfer, HOLD keeps a locked owner
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      lock_cnt_q <= 4'd0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      lock_err_q <= 1'b0;
      rdata0_q   <= 8'd0;
      rdata1_q   <= 8'd0;
    end else begin
      lock_err_q <= 1'b0;
      case (state_q)
        IDLE: if (req0_i | req1_i) begin
          owner_q <= winner;
          gnt0_q  <= ~winner;
          gnt1_q  <= winner;
          state_q <= ACCESS;
        end
        ACCESS: begin
          last_q <= owner_q;
          if (o_req & ~o_we & ~owner_q) rdata0_q <= ram_q_i;
          if (o_req & ~o_we & owner_q) rdata1_q <= ram_q_i;
          if (o_req & o_lock) begin
            state_q    <= HOLD;
            lock_cnt_q <= 4'd0;
          end else begin
            state_q <= IDLE;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
          end
        end
        HOLD: if (o_req) begin
          state_q    <= ACCESS;
          lock_cnt_q <= 4'd0;
        end else if (!o_lock || lock_cnt_q == 4'(LOCK_MAX - 1)) begin
          state_q    <= IDLE;
          gnt0_q     <= 1'b0;
          gnt1_q     <= 1'b0;
          lock_err_q <= o_lock;
        end else begin
          lock_cnt_q <= lock_cnt_d;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign gnt0_o     = gnt0_q;
  assign gnt1_o     = gnt1_q;
  assign rdata0_o   = rdata0_q;
  assign rdata1_o   = rdata1_q;
  assign lock_err_o = lock_err_q;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed + randomized self-checking bench for ram_port_arbiter
module tb_ram_port_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic init_done = 1'b0;
  logic req0 = 0, req1 = 0, we0 = 0, we1 = 0, lock0 = 0, lock1 = 0;
  logic [6:0] addr0 = 0, addr1 = 0;
  logic [7:0] wdata0 = 0, wdata1 = 0;
  logic gnt0, gnt1, ack0, ack1, lock_err, ram_en;
  logic [7:0] rdata0, rdata1, ram_data, ram_q;
  logic [6:0] ram_addr;
  logic p_gnt0, p_gnt1, p_ack0, p_ack1, p_lock_err, p_ram_en;
  logic [7:0] p_rdata0, p_rdata1, p_ram_data, p_ram_q;
  logic [6:0] p_ram_addr;
  logic [7:0] mem [128];
  logic [7:0] mem_p [128];
  logic [7:0] ref_mem [128];
  int checks = 0, errors = 0;
  int last_port;

  always #5 clk = ~clk;

  ram_port_arbiter #(.CPU_PRIO(1'b0), .LOCK_MAX(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req0_i(req0), .req1_i(req1), .we0_i(we0), .we1_i(we1),
    .addr0_i(addr0), .addr1_i(addr1), .wdata0_i(wdata0), .wdata1_i(wdata1),
    .lock0_i(lock0), .lock1_i(lock1), .gnt0_o(gnt0), .gnt1_o(gnt1), .ack0_o(ack0), .ack1_o(ack1),
    .rdata0_o(rdata0), .rdata1_o(rdata1), .lock_err_o(lock_err), .ram_addr_o(ram_addr),
    .ram_data_o(ram_data), .ram_en_o(ram_en), .ram_q_i(ram_q));

  ram_port_arbiter #(.CPU_PRIO(1'b1), .LOCK_MAX(8)) dut_prio (
    .clk_i(clk), .rst_ni(rst_n), .req0_i(req0), .req1_i(req1), .we0_i(we0), .we1_i(we1),
    .addr0_i(addr0), .addr1_i(addr1), .wdata0_i(wdata0), .wdata1_i(wdata1),
    .lock0_i(lock0), .lock1_i(lock1), .gnt0_o(p_gnt0), .gnt1_o(p_gnt1), .ack0_o(p_ack0), .ack1_o(p_ack1),
    .rdata0_o(p_rdata0), .rdata1_o(p_rdata1), .lock_err_o(p_lock_err), .ram_addr_o(p_ram_addr),
    .ram_data_o(p_ram_data), .ram_en_o(p_ram_en), .ram_q_i(p_ram_q));

  function automatic logic [7:0] init_val(input int i);
    return (i == 'h12) ? 8'h5A : (i == 'h20) ? 8'h03 : (8'(i) ^ 8'hA5);
  endfunction

  assign ram_q   = mem[ram_addr];
  assign p_ram_q = mem_p[p_ram_addr];

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 128; i++) begin
        mem[i]   <= init_val(i);
        mem_p[i] <= init_val(i);
      end
    end else begin
      if (ram_en) mem[ram_addr] <= ram_data;
      if (p_ram_en) mem_p[p_ram_addr] <= p_ram_data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic r, input logic w, input logic [6:0] a,
                          input logic [7:0] d, input logic l);
    if (p == 0) begin
      req0 = r; we0 = w; addr0 = a; wdata0 = d; lock0 = l;
    end else begin
      req1 = r; we1 = w; addr1 = a; wdata1 = d; lock1 = l;
    end
  endtask

  task automatic wait_ack(input int p, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = (p != 0) ? ack1 : ack0;
    end
  endtask

  task automatic rd(input int p, input logic [6:0] a, output logic [7:0] q);
    bit ok;
    tick();
    set_port(p, 1'b1, 1'b0, a, 8'd0, 1'b0);
    wait_ack(p, ok);
    chk("rd_ack", 32'(ok), 1);
    tick();
    set_port(p, 1'b0, 1'b0, a, 8'd0, 1'b0);
    @(negedge clk);
    q = (p != 0) ? rdata1 : rdata0;
    last_port = p;
  endtask

  // Protocol invariants checked every cycle outside reset
  always @(negedge clk) begin
    if (rst_n && init_done) begin
      chk("inv_mutex", 32'(gnt0 & gnt1), 0);
      chk("inv_ack_gnt", 32'((ack0 & ~gnt0) | (ack1 & ~gnt1)), 0);
      chk("inv_en_ack", 32'(ram_en & ~(ack0 | ack1)), 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  bit ok;
  logic [7:0] q;
  int exp_port, hold, le_cnt, le_at, ack1_at, nacks;
  bit pend [2], acked [2], rwe [2], chk_rd [2];
  logic [6:0] ra [2];
  logic [7:0] rwd [2], exp_rd [2];
  int wait_c [2];

  initial begin
    for (int i = 0; i < 128; i++) ref_mem[i] = init_val(i);
    repeat (2) @(posedge clk);
    #1 init_done = 1'b1;
    @(negedge clk);
    chk("rst_gnt", 32'({gnt0, gnt1}), 0);
    chk("rst_ack", 32'({ack0, ack1}), 0);
    chk("rst_rdata", 32'({rdata0, rdata1}), 0);
    chk("rst_lock_err", 32'(lock_err), 0);
    chk("rst_ram", 32'({ram_en, ram_addr, ram_data}), 0);
    rst_n = 1'b1;
    last_port = 1;

    // Single read of 0x12 by port 0
    tick();
    set_port(0, 1'b1, 1'b0, 7'h12, 8'd0, 1'b0);
    @(negedge clk);
    chk("rd_c0_gnt0", 32'(gnt0), 0);
    @(negedge clk);
    chk("rd_c1_gnt0", 32'(gnt0), 1);
    chk("rd_c1_ack0", 32'(ack0), 1);
    chk("rd_c1_en", 32'(ram_en), 0);
    chk("rd_c1_addr", 32'(ram_addr), 'h12);
    tick();
    set_port(0, 1'b0, 1'b0, 7'h12, 8'd0, 1'b0);
    @(negedge clk);
    chk("rd_c2_rdata0", 32'(rdata0), 'h5A);
    chk("rd_c2_gnt0", 32'(gnt0), 0);
    last_port = 0;

    // Single write of 0x7F to 0x05 by port 1
    tick();
    set_port(1, 1'b1, 1'b1, 7'h05, 8'h7F, 1'b0);
    @(negedge clk);
    chk("wr_c0_en", 32'(ram_en), 0);
    @(negedge clk);
    chk("wr_c1_ack1", 32'(ack1), 1);
    chk("wr_c1_en", 32'(ram_en), 1);
    chk("wr_c1_addr", 32'(ram_addr), 'h05);
    chk("wr_c1_data", 32'(ram_data), 'h7F);
    tick();
    set_port(1, 1'b0, 1'b0, 7'h05, 8'd0, 1'b0);
    @(negedge clk);
    chk("wr_c2_en", 32'(ram_en), 0);
    chk("wr_rdata1_kept", 32'(rdata1), 0);
    ref_mem[5] = 8'h7F;
    last_port = 1;
    rd(0, 7'h05, q);
    chk("wr_readback", 32'(q), 'h7F);

    // Both ports request continuously: round-robin alternates, CPU_PRIO instance always picks 0
    tick();
    set_port(0, 1'b1, 1'b0, 7'h01, 8'd0, 1'b0);
    set_port(1, 1'b1, 1'b0, 7'h02, 8'd0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      ok = 1'b0;
      for (int i = 0; i < 4 && !ok; i++) begin
        @(negedge clk);
        ok = ack0 | ack1;
      end
      exp_port = 1 - last_port;
      chk("rr_seen", 32'(ok), 1);
      chk("rr_winner", 32'(ack1), 32'(exp_port));
      chk("prio_winner", 32'({p_ack0, p_ack1}), 'b10);
      last_port = exp_port;
    end
    tick();
    set_port(0, 1'b0, 1'b0, 7'h01, 8'd0, 1'b0);
    set_port(1, 1'b0, 1'b0, 7'h02, 8'd0, 1'b0);

    // Locked read-modify-write on 0x20 while port 1 waits
    tick();
    set_port(0, 1'b1, 1'b0, 7'h20, 8'd0, 1'b1);
    wait_ack(0, ok);
    chk("rmw_rd_ack", 32'(ok), 1);
    tick();
    set_port(0, 1'b1, 1'b1, 7'h20, 8'h07, 1'b0);
    set_port(1, 1'b1, 1'b0, 7'h21, 8'd0, 1'b0);
    @(negedge clk);
    chk("rmw_rdata0", 32'(rdata0), 'h03);
    chk("rmw_hold_gnt", 32'({gnt0, gnt1}), 'b10);
    @(negedge clk);
    chk("rmw_wr_ack0", 32'(ack0), 1);
    chk("rmw_wr_bus", 32'({ram_en, ram_addr, ram_data}), 32'({1'b1, 7'h20, 8'h07}));
    chk("rmw_gnt1", 32'(gnt1), 0);
    tick();
    set_port(0, 1'b0, 1'b0, 7'h20, 8'd0, 1'b0);
    ref_mem['h20] = 8'h07;
    wait_ack(1, ok);
    chk("rmw_p1_ack", 32'(ok), 1);
    tick();
    set_port(1, 1'b0, 1'b0, 7'h21, 8'd0, 1'b0);
    @(negedge clk);
    chk("rmw_p1_rdata", 32'(rdata1), 32'(ref_mem['h21]));
    last_port = 1;
    rd(1, 7'h20, q);
    chk("rmw_result", 32'(q), 'h07);

    // Lock timeout: port 0 holds with lock high and no request
    tick();
    set_port(0, 1'b1, 1'b0, 7'h30, 8'd0, 1'b1);
    wait_ack(0, ok);
    chk("to_ack0", 32'(ok), 1);
    tick();
    set_port(0, 1'b0, 1'b0, 7'h30, 8'd0, 1'b1);
    set_port(1, 1'b1, 1'b0, 7'h31, 8'd0, 1'b0);
    hold = 0; le_cnt = 0; le_at = -1; ack1_at = -1;
    for (int k = 0; k < 20 && ack1_at < 0; k++) begin
      @(negedge clk);
      if (gnt0) hold++;
      if (lock_err) begin le_cnt++; le_at = k; end
      if (ack1) ack1_at = k;
    end
    chk("to_hold_cycles", 32'(hold), 8);
    chk("to_lock_err_cnt", 32'(le_cnt), 1);
    chk("to_lock_err_at", 32'(le_at), 8);
    chk("to_ack1_at", 32'(ack1_at), 9);
    tick();
    set_port(0, 1'b0, 1'b0, 7'h30, 8'd0, 1'b0);
    set_port(1, 1'b0, 1'b0, 7'h31, 8'd0, 1'b0);
    @(negedge clk);
    chk("to_lock_err_low", 32'(lock_err), 0);
    chk("to_rdata1", 32'(rdata1), 32'(ref_mem['h31]));

    // Reset asserted mid-write
    tick();
    set_port(1, 1'b1, 1'b1, 7'h10, 8'h55, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("mr_en_before", 32'(ram_en), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_en", 32'(ram_en), 0);
    chk("mr_gnt", 32'({gnt0, gnt1}), 0);
    chk("mr_ack", 32'({ack0, ack1}), 0);
    chk("mr_rdata", 32'({rdata0, rdata1}), 0);
    tick();
    set_port(1, 1'b0, 1'b0, 7'h10, 8'd0, 1'b0);
    chk("mr_cell", 32'(mem['h10]), 32'(ref_mem['h10]));
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic against a memory reference model
    nacks = 0;
    for (int p = 0; p < 2; p++) begin
      pend[p] = 0; acked[p] = 0; chk_rd[p] = 0; wait_c[p] = 0;
    end
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        acked[p] = 1'b0;
        if (chk_rd[p]) begin
          chk("rnd_rdata", 32'((p != 0) ? rdata1 : rdata0), 32'(exp_rd[p]));
          chk_rd[p] = 1'b0;
        end
        if ((p != 0) ? ack1 : ack0) begin
          nacks++;
          acked[p] = 1'b1;
          chk("rnd_addr", 32'(ram_addr), 32'(ra[p]));
          chk("rnd_en", 32'(ram_en), 32'(rwe[p]));
          if (rwe[p]) begin
            chk("rnd_wdata", 32'(ram_data), 32'(rwd[p]));
            ref_mem[ra[p]] = rwd[p];
          end else begin
            exp_rd[p] = ref_mem[ra[p]];
            chk_rd[p] = 1'b1;
          end
        end else if (pend[p]) begin
          wait_c[p]++;
          chk("rnd_wait_bound", 32'(wait_c[p] > 40), 0);
          if (wait_c[p] > 40) wait_c[p] = 0;
        end
      end
      tick();
      for (int p = 0; p < 2; p++) begin
        if (acked[p]) begin
          pend[p] = 1'b0;
          set_port(p, 1'b0, 1'b0, ra[p], 8'd0, 1'($urandom_range(0, 1)));
        end else if (!pend[p] && $urandom_range(0, 2) == 0) begin
          pend[p] = 1'b1;
          wait_c[p] = 0;
          rwe[p] = 1'($urandom_range(0, 1));
          ra[p] = 7'h40 + 7'($urandom_range(0, 15));
          rwd[p] = 8'($urandom);
          set_port(p, 1'b1, rwe[p], ra[p], rwd[p], $urandom_range(0, 3) == 0);
        end
      end
    end
    set_port(0, 1'b0, 1'b0, 7'd0, 8'd0, 1'b0);
    set_port(1, 1'b0, 1'b0, 7'd0, 8'd0, 1'b0);
    repeat (12) @(negedge clk);
    chk("rnd_activity", 32'(nacks > 100), 1);
    for (int a = 'h40; a < 'h50; a++) chk("rnd_mem", 32'(mem[a]), 32'(ref_mem[a]));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
